// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
package fetch_unit_pkg;

  localparam int unsigned FU_WORD_SIZE = 16;
  localparam logic [15:0] FU_RESET_PC  = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_SPACE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_buffer.sv
// Two-entry in-order fetch buffer (head + skid) between the fetch FSM and IF/ID.
// A write lands in the first free entry; the head counts as free when it is
// consumed on the same edge. Clear drops both entries and wins over everything.
module fetch_buffer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_pc,
  input  logic             consume,
  output logic [WIDTH-1:0] head_data,
  output logic [WIDTH-1:0] head_pc,
  output logic             head_valid,
  output logic             full
);

  logic [WIDTH-1:0] skid_data;
  logic [WIDTH-1:0] skid_pc;
  logic             skid_valid;

  assign full = skid_valid;

  // Entry update: clear, then consume/shift, then write into the first free slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_data  <= '0;
      head_pc    <= '0;
      head_valid <= 1'b0;
      skid_data  <= '0;
      skid_pc    <= '0;
      skid_valid <= 1'b0;
    end else if (clear) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (consume) begin
      head_valid <= skid_valid | wr_en;
      if (skid_valid) begin
        head_data <= skid_data;
        head_pc   <= skid_pc;
      end else if (wr_en) begin
        head_data <= wr_data;
        head_pc   <= wr_pc;
      end
      skid_valid <= skid_valid & wr_en;
      if (skid_valid && wr_en) begin
        skid_data <= wr_data;
        skid_pc   <= wr_pc;
      end
    end else if (wr_en) begin
      if (!head_valid) begin
        head_data  <= wr_data;
        head_pc    <= wr_pc;
        head_valid <= 1'b1;
      end else begin
        skid_data  <= wr_data;
        skid_pc    <= wr_pc;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequences instruction-memory reads, drops
// wrong-path data after a flush, and feeds IF/ID through a 2-entry buffer.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned          WORD_SIZE = FU_WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = FU_RESET_PC
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush_signal,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 stall,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_ready,
  output logic [WORD_SIZE-1:0] instr,
  output logic [WORD_SIZE-1:0] instr_pc,
  output logic                 instr_valid
);

  fetch_state_e         state, state_n;
  logic [WORD_SIZE-1:0] pc, pc_n;
  logic [WORD_SIZE-1:0] req_addr, req_n, req_inc;
  logic                 drop, drop_n;
  logic                 wr_en;
  logic                 consume;
  logic                 full;
  logic [1:0]           occ;
  logic [1:0]           kept;

  assign consume   = instr_valid & ~stall;
  assign occ       = {1'b0, instr_valid} + {1'b0, full};
  // Entries still occupied after this edge's consume, before any write.
  assign kept      = occ - {1'b0, consume};
  assign req_inc   = req_addr + {{(WORD_SIZE-1){1'b0}}, 1'b1};
  assign i_readM   = (state == S_REQ);
  assign i_address = req_addr;

  // FSM, fetch pointer, request address and wrong-path drop flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      drop     <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_addr <= req_n;
      drop     <= drop_n;
    end
  end

  // Next-state logic: flush first, then memory completion, then buffer space.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    req_n   = req_addr;
    drop_n  = drop;
    wr_en   = 1'b0;
    case (state)
      S_IDLE: begin
        state_n = S_REQ;
        if (flush_signal) begin
          pc_n  = redirect_pc;
          req_n = redirect_pc;
        end else begin
          req_n = pc;
        end
      end
      S_REQ: begin
        if (drop) begin
          if (flush_signal) pc_n = redirect_pc;
          // Stale read finishing: a flush on this same edge supplies the target directly.
          if (i_ready) begin
            drop_n = 1'b0;
            req_n  = flush_signal ? redirect_pc : pc;
          end
        end else if (flush_signal) begin
          pc_n = redirect_pc;
          if (i_ready) req_n = redirect_pc;
          else         drop_n = 1'b1;
        end else if (i_ready) begin
          wr_en = 1'b1;
          pc_n  = req_inc;
          // Skid is always free in S_REQ, so the write fills it only if the head stays.
          if (kept != 2'd0) state_n = S_SPACE;
          else              req_n   = req_inc;
        end
      end
      S_SPACE: begin
        if (flush_signal) begin
          state_n = S_REQ;
          pc_n    = redirect_pc;
          req_n   = redirect_pc;
        end else if (kept != 2'd2) begin
          state_n = S_REQ;
          req_n   = pc;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  fetch_buffer #(
    .WIDTH(WORD_SIZE)
  ) u_buffer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (flush_signal),
    .wr_en     (wr_en),
    .wr_data   (i_data),
    .wr_pc     (req_addr),
    .consume   (consume),
    .head_data (instr),
    .head_pc   (instr_pc),
    .head_valid(instr_valid),
    .full      (full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: variable-latency memory responder plus a
// queue-based model of the correct-path instruction stream.
module tb_fetch_unit;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush_signal;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        i_readM;
  logic [15:0] i_address;
  logic [15:0] i_data;
  logic        i_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;

  always #5 clk = ~clk;

  fetch_unit #(
    .WORD_SIZE(16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_signal(flush_signal),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .i_readM     (i_readM),
    .i_address   (i_address),
    .i_data      (i_data),
    .i_ready     (i_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
  );

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned fails  = 0;

  // Model: instructions the IF/ID side should see, in order.
  logic [15:0] q[$];
  logic [15:0] fetch_ptr;
  // Memory responder state.
  bit          req_active;
  bit          stale;
  int          cnt;
  int          lat;
  int          forced_lat;
  logic [15:0] mreq_addr;
  bit          hit;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Decide memory response for the coming edge from the current request.
  task automatic prep_mem();
    if (i_readM === 1'b1) begin
      if (!req_active) begin
        req_active = 1'b1;
        cnt        = 0;
        lat        = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 3));
        mreq_addr  = i_address;
      end else begin
        chk("addr_stable", i_address, mreq_addr);
        cnt++;
      end
      i_ready = (cnt >= lat);
      i_data  = i_ready ? mem_word(i_address) : 16'hDEAD;
    end else begin
      if (req_active) chk("readm_held", i_readM, 1'b1);
      i_ready = 1'b0;
      i_data  = 16'hDEAD;
    end
  endtask

  // Apply inputs, advance the model across the edge, then check outputs.
  task automatic edge_step(input logic fl, input logic [15:0] rpc, input logic st);
    flush_signal = fl;
    redirect_pc  = rpc;
    stall        = st;
    if (fl) begin
      q.delete();
      fetch_ptr = rpc;
      if (req_active && !i_ready) stale = 1'b1;
    end else begin
      if (q.size() != 0 && !st) q.delete(0);
      if (i_ready && !stale) begin
        chk("fetch_addr", i_address, fetch_ptr);
        q.push_back(fetch_ptr);
        fetch_ptr = fetch_ptr + 16'd1;
      end
    end
    if (i_ready) begin
      req_active = 1'b0;
      stale      = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("instr_valid", instr_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("instr_pc", instr_pc, q[0]);
      chk("instr", instr, mem_word(q[0]));
    end
  endtask

  task automatic step(input logic fl, input logic [15:0] rpc, input logic st);
    prep_mem();
    edge_step(fl, rpc, st);
  endtask

  initial begin
    reset_n      = 1'b0;
    flush_signal = 1'b0;
    redirect_pc  = '0;
    stall        = 1'b0;
    i_ready      = 1'b0;
    i_data       = '0;
    forced_lat   = 0;
    fetch_ptr    = RST_PC;
    req_active   = 1'b0;
    stale        = 1'b0;

    // Reset state
    #12;
    chk("rst_readm", i_readM, 1'b0);
    chk("rst_addr", i_address, RST_PC);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_instr_pc", instr_pc, 16'h0000);
    chk("rst_valid", instr_valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 16'h0, 1'b0);

    // Back-to-back fetch with single-cycle memory
    for (int k = 0; k < 4; k++) begin
      chk("seq_readm", i_readM, 1'b1);
      chk("seq_addr", i_address, k);
      step(1'b0, 16'h0, 1'b0);
    end

    // Stall fills head and skid, fetch pauses
    step(1'b1, 16'h0010, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1);
    chk("space_readm", i_readM, 1'b0);
    chk("space_addr", i_address, 16'h0011);
    chk("space_head", instr_pc, 16'h0010);
    step(1'b0, 16'h0, 1'b0);
    chk("drain_pc", instr_pc, 16'h0011);
    chk("resume_readm", i_readM, 1'b1);
    chk("resume_addr", i_address, 16'h0012);
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);

    // Flush while a slow read is outstanding
    step(1'b1, 16'h0020, 1'b0);
    forced_lat = 4;
    chk("slow_readm", i_readM, 1'b1);
    chk("slow_addr", i_address, 16'h0020);
    step(1'b0, 16'h0, 1'b0);
    forced_lat = 0;
    step(1'b1, 16'h0080, 1'b0);
    for (int i = 0; i < 10 && i_address !== 16'h0080; i++) begin
      chk("drop_readm", i_readM, 1'b1);
      chk("drop_addr", i_address, 16'h0020);
      step(1'b0, 16'h0, 1'b0);
    end
    chk("redir_addr", i_address, 16'h0080);
    chk("redir_readm", i_readM, 1'b1);
    for (int i = 0; i < 10 && instr_valid !== 1'b1; i++) step(1'b0, 16'h0, 1'b0);
    chk("redir_first_pc", instr_pc, 16'h0080);

    // Flush on the same edge as the read completes
    forced_lat = 2;
    step(1'b1, 16'h0005, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      prep_mem();
      if (i_ready === 1'b1 && i_address === 16'h0005) begin
        hit = 1'b1;
        edge_step(1'b1, 16'h0040, 1'b0);
        break;
      end
      edge_step(1'b0, 16'h0, 1'b0);
    end
    chk("same_edge_hit", hit, 1'b1);
    chk("same_edge_readm", i_readM, 1'b1);
    chk("same_edge_addr", i_address, 16'h0040);

    // Flush with a full buffer under stall
    forced_lat = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b1);
    chk("full_readm", i_readM, 1'b0);
    chk("full_valid", instr_valid, 1'b1);
    step(1'b1, 16'h0100, 1'b1);
    chk("full_flush_valid", instr_valid, 1'b0);
    chk("full_flush_readm", i_readM, 1'b1);
    chk("full_flush_addr", i_address, 16'h0100);

    // Address wrap
    step(1'b1, 16'hFFFF, 1'b0);
    chk("wrap_top", i_address, 16'hFFFF);
    step(1'b0, 16'h0, 1'b0);
    chk("wrap_readm", i_readM, 1'b1);
    chk("wrap_addr", i_address, 16'h0000);
    step(1'b0, 16'h0, 1'b0);

    // Asynchronous reset in the middle of a request
    forced_lat = 6;
    step(1'b1, 16'h0033, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    chk("mid_req_readm", i_readM, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_readm", i_readM, 1'b0);
    chk("async_valid", instr_valid, 1'b0);
    chk("async_addr", i_address, RST_PC);
    q.delete();
    fetch_ptr  = RST_PC;
    req_active = 1'b0;
    stale      = 1'b0;
    i_ready    = 1'b0;
    forced_lat = 0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 16'h0, 1'b0);
    chk("post_rst_readm", i_readM, 1'b1);
    chk("post_rst_addr", i_address, RST_PC);

    // Random traffic against the model
    forced_lat = -1;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 19) == 0, 16'($urandom), $urandom_range(0, 9) < 3);
    end
    for (int i = 0; i < 12 && instr_valid !== 1'b1; i++) step(1'b0, 16'h0, 1'b0);
    chk("liveness", instr_valid, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
